// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-vote sampling, runtime
// prescale, optional parity and one or two stop bits.
module uart_rx_ovs #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic [PWIDTH-1:0] prescale,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              stop2,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              par_err,
    output logic              stop_err,
    output logic              busy
);

    localparam int BW = $clog2(DWIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [1:0]        sync_q;
    logic              rx_s;
    logic [PWIDTH-1:0] edge_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              stop_idx;
    logic [PWIDTH-1:0] p_l;
    logic              pe_l;
    logic              pt_l;
    logic              s2_l;
    logic [1:0]        samp;
    logic [DWIDTH-1:0] shreg;
    logic              par_err_int;
    logic              stop_err_int;

    logic [PWIDTH-1:0] p_clamp;
    logic [PWIDTH-1:0] mid;
    logic              at_mid_m1;
    logic              at_mid;
    logic              at_res;
    logic              at_end;
    logic              maj;
    logic              last_bit;
    logic              last_stop;
    logic              start_det;
    logic              frame_done;

    assign rx_s       = sync_q[1];
    assign p_clamp    = (prescale < PWIDTH'(4)) ? PWIDTH'(4) : prescale;
    assign mid        = p_l >> 1;
    assign at_mid_m1  = (edge_cnt == mid - PWIDTH'(1));
    assign at_mid     = (edge_cnt == mid);
    assign at_res     = (edge_cnt == mid + PWIDTH'(1));
    assign at_end     = (edge_cnt == p_l - PWIDTH'(1));
    assign maj        = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign last_bit   = (bit_cnt == BW'(DWIDTH - 1));
    assign last_stop  = (stop_idx == s2_l);
    assign start_det  = (state_q == IDLE) && !rx_s;
    assign frame_done = (state_q == STOP) && at_res && last_stop;
    assign busy       = (state_q != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; glitch rejection wins over end-of-bit
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                if (at_res && maj) state_d = IDLE;
                else if (at_end) state_d = DATA;
            end
            DATA: begin
                if (at_end && last_bit) state_d = pe_l ? PARITY : STOP;
            end
            PARITY: begin
                if (at_end) state_d = STOP;
            end
            STOP: begin
                if (at_res && last_stop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchroniser, bit timing, sampling, shifting and frame outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= 2'b11;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            stop_idx     <= 1'b0;
            p_l          <= '0;
            pe_l         <= 1'b0;
            pt_l         <= 1'b0;
            s2_l         <= 1'b0;
            samp         <= 2'b00;
            shreg        <= '0;
            par_err_int  <= 1'b0;
            stop_err_int <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_in};
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            if (start_det) begin
                p_l          <= p_clamp;
                pe_l         <= par_en;
                pt_l         <= par_typ;
                s2_l         <= stop2;
                edge_cnt     <= '0;
                bit_cnt      <= '0;
                stop_idx     <= 1'b0;
                par_err_int  <= 1'b0;
                stop_err_int <= 1'b0;
            end else if (state_q != IDLE) begin
                edge_cnt <= at_end ? '0 : edge_cnt + PWIDTH'(1);
                if (at_mid_m1) samp[0] <= rx_s;
                if (at_mid)    samp[1] <= rx_s;
                if (at_res) begin
                    if (state_q == DATA) begin
                        shreg <= {maj, shreg[DWIDTH-1:1]};
                    end
                    if (state_q == PARITY) begin
                        par_err_int <= maj ^ (^shreg) ^ pt_l;
                    end
                    if (state_q == STOP) begin
                        stop_err_int <= stop_err_int | ~maj;
                    end
                end
                if (frame_done) begin
                    data_out   <= shreg;
                    data_valid <= 1'b1;
                    par_err    <= pe_l & par_err_int;
                    stop_err   <= stop_err_int | ~maj;
                end
                if (at_end && state_q == DATA && !last_bit) begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
                if (at_end && state_q == STOP) begin
                    stop_idx <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: framing, parity, glitch, noise,
// back-to-back, reset abort, prescale clamp and a 9-bit instance.
module tb_uart_rx_ovs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_in = 1'b1;
    logic        rx_in2 = 1'b1;
    logic [5:0]  prescale = 6'd8;
    logic        par_en = 1'b0;
    logic        par_typ = 1'b0;
    logic        stop2 = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid, par_err, stop_err, busy;
    logic [8:0]  data_out2;
    logic        data_valid2, par_err2, stop_err2, busy2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    uart_rx_ovs #(.DWIDTH(8), .PWIDTH(6)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
        .data_out(data_out), .data_valid(data_valid),
        .par_err(par_err), .stop_err(stop_err), .busy(busy)
    );

    uart_rx_ovs #(.DWIDTH(9), .PWIDTH(6)) dut9 (
        .clk(clk), .rst(rst), .rx_in(rx_in2), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
        .data_out(data_out2), .data_valid(data_valid2),
        .par_err(par_err2), .stop_err(stop_err2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Frame monitor for the 8-bit instance
    logic [15:0] m_data [64];
    bit          m_par  [64];
    bit          m_stop [64];
    int          m_lat  [64];
    int          m_blen [64];
    int vld_cnt = 0, busy_rise = 0, last_blen = 0, dv_multi = 0, t0 = 0;
    bit busy_q = 0, dv_q = 0;

    always @(negedge clk) begin
        if (busy && !busy_q) begin
            t0 = cyc;
            busy_rise++;
        end
        if (!busy && busy_q) last_blen = cyc - t0;
        if (data_valid) begin
            if (vld_cnt < 64) begin
                m_data[vld_cnt] = 16'(data_out);
                m_par[vld_cnt]  = par_err;
                m_stop[vld_cnt] = stop_err;
                m_lat[vld_cnt]  = cyc - t0;
                m_blen[vld_cnt] = last_blen;
            end
            vld_cnt++;
        end
        if (data_valid && dv_q) dv_multi++;
        busy_q = busy;
        dv_q = data_valid;
    end

    // Frame monitor for the 9-bit instance
    int vld2_cnt = 0, t0_2 = 0, lat2 = 0;
    logic [15:0] d2 = '0;
    bit p2 = 0, s2e = 0, busy2_q = 0;

    always @(negedge clk) begin
        if (busy2 && !busy2_q) t0_2 = cyc;
        if (data_valid2) begin
            d2  = 16'(data_out2);
            p2  = par_err2;
            s2e = stop_err2;
            lat2 = cyc - t0_2;
            vld2_cnt++;
        end
        busy2_q = busy2;
    end

    task automatic send_frame(input int sel, input logic [15:0] d,
                              input int dw, input int p, input bit pe,
                              input bit pb, input int ns,
                              input logic [1:0] sv, input int nb,
                              input int no);
        logic [31:0] v;
        logic x;
        int n;
        v = '1;
        n = 0;
        v[n] = 1'b0;
        n++;
        for (int i = 0; i < dw; i++) begin
            v[n] = d[i];
            n++;
        end
        if (pe) begin
            v[n] = pb;
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            v[n] = sv[i];
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < p; i++) begin
                x = v[b];
                if (b == nb && i == no) x = ~x;
                if (sel == 0) rx_in = x;
                else rx_in2 = x;
                @(posedge clk);
                #1;
            end
        end
        rx_in = 1'b1;
        rx_in2 = 1'b1;
    endtask

    task automatic wait_vld(input int target, input int budget);
        for (int i = 0; i < budget && vld_cnt < target; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: got %b want 0", data_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_data: got %h want 00", data_out);
        end
        checks++;
        if (par_err !== 1'b0 || stop_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags: got %b%b want 00", par_err, stop_err);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int base;
        prescale = 6'd8; par_en = 1'b0; stop2 = 1'b0;
        base = vld_cnt;
        send_frame(0, 16'h00A5, 8, 8, 0, 0, 1, 2'b11, -1, 0);
        wait_vld(base + 1, 40);
        checks++;
        if (vld_cnt !== base + 1) begin
            errors++;
            $display("FAIL basic_count: got %0d want %0d", vld_cnt, base + 1);
        end
        checks++;
        if (m_data[base] !== 16'h00A5) begin
            errors++;
            $display("FAIL basic_data: got %h want 00a5", m_data[base]);
        end
        checks++;
        if (m_par[base] !== 1'b0 || m_stop[base] !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: got %b%b want 00", m_par[base], m_stop[base]);
        end
        checks++;
        if (m_lat[base] !== 78) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 78", m_lat[base]);
        end
        checks++;
        if (m_blen[base] !== 78) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d want 78", m_blen[base]);
        end
    endtask

    task automatic test_parity;
        int base;
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        base = vld_cnt;
        send_frame(0, 16'h00A5, 8, 8, 1, 1, 1, 2'b11, -1, 0);
        wait_vld(base + 1, 40);
        send_frame(0, 16'h00A5, 8, 8, 1, 0, 1, 2'b11, -1, 0);
        wait_vld(base + 2, 40);
        checks++;
        if (vld_cnt !== base + 2) begin
            errors++;
            $display("FAIL par_count: got %0d want %0d", vld_cnt, base + 2);
        end
        checks++;
        if (m_data[base] !== 16'h00A5 || m_par[base] !== 1'b1) begin
            errors++;
            $display("FAIL par_bad: got %h/%b want 00a5/1", m_data[base], m_par[base]);
        end
        checks++;
        if (m_lat[base] !== 86) begin
            errors++;
            $display("FAIL par_latency: got %0d want 86", m_lat[base]);
        end
        checks++;
        if (m_data[base+1] !== 16'h00A5 || m_par[base+1] !== 1'b0
            || m_stop[base+1] !== 1'b0) begin
            errors++;
            $display("FAIL par_good: got %h/%b/%b want 00a5/0/0",
                     m_data[base+1], m_par[base+1], m_stop[base+1]);
        end
        par_en = 1'b0;
    endtask

    task automatic test_glitch;
        int base;
        int br;
        prescale = 6'd8; par_en = 1'b0; stop2 = 1'b0;
        base = vld_cnt;
        br = busy_rise;
        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (vld_cnt !== base) begin
            errors++;
            $display("FAIL glitch_valid: got %0d want %0d", vld_cnt, base);
        end
        checks++;
        if (busy_rise !== br + 1 || last_blen !== 6) begin
            errors++;
            $display("FAIL glitch_busy: rises %0d len %0d want %0d len 6",
                     busy_rise, last_blen, br + 1);
        end
        send_frame(0, 16'h003C, 8, 8, 0, 0, 1, 2'b11, -1, 0);
        wait_vld(base + 1, 40);
        checks++;
        if (vld_cnt !== base + 1 || m_data[base] !== 16'h003C) begin
            errors++;
            $display("FAIL glitch_next: got %0d/%h want %0d/003c",
                     vld_cnt, m_data[base], base + 1);
        end
    endtask

    task automatic test_noise;
        int base;
        prescale = 6'd8; par_en = 1'b0; stop2 = 1'b0;
        base = vld_cnt;
        send_frame(0, 16'h00FF, 8, 8, 0, 0, 1, 2'b11, 4, 5);
        wait_vld(base + 1, 40);
        checks++;
        if (vld_cnt !== base + 1 || m_data[base] !== 16'h00FF
            || m_stop[base] !== 1'b0 || m_par[base] !== 1'b0) begin
            errors++;
            $display("FAIL noise: got %0d/%h/%b%b want %0d/00ff/00",
                     vld_cnt, m_data[base], m_par[base], m_stop[base], base + 1);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        logic [3:0] pat;
        prescale = 6'd8; par_en = 1'b0; stop2 = 1'b0;
        base = vld_cnt;
        pat = 4'b0100;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                rx_in = pat[b];
                @(posedge clk);
                #1;
            end
        end
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'h00
            || par_err !== 1'b0 || stop_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outs: got %b%b %h %b%b want 00 00 00",
                     busy, data_valid, data_out, par_err, stop_err);
        end
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (vld_cnt !== base) begin
            errors++;
            $display("FAIL mid_no_valid: got %0d want %0d", vld_cnt, base);
        end
        send_frame(0, 16'h0081, 8, 8, 0, 0, 1, 2'b11, -1, 0);
        wait_vld(base + 1, 40);
        checks++;
        if (vld_cnt !== base + 1 || m_data[base] !== 16'h0081
            || m_lat[base] !== 78) begin
            errors++;
            $display("FAIL mid_next: got %0d/%h/%0d want %0d/0081/78",
                     vld_cnt, m_data[base], m_lat[base], base + 1);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1;
        base = vld_cnt;
        send_frame(0, 16'h0000, 8, 16, 1, 1, 2, 2'b11, -1, 0);
        send_frame(0, 16'h00FF, 8, 16, 1, 1, 2, 2'b11, -1, 0);
        wait_vld(base + 2, 60);
        checks++;
        if (vld_cnt !== base + 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want %0d", vld_cnt, base + 2);
        end
        checks++;
        if (m_data[base] !== 16'h0000 || m_par[base] !== 1'b0
            || m_stop[base] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got %h/%b%b want 0000/00",
                     m_data[base], m_par[base], m_stop[base]);
        end
        checks++;
        if (m_data[base+1] !== 16'h00FF || m_par[base+1] !== 1'b0
            || m_stop[base+1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got %h/%b%b want 00ff/00",
                     m_data[base+1], m_par[base+1], m_stop[base+1]);
        end
        checks++;
        if (m_lat[base+1] !== 186) begin
            errors++;
            $display("FAIL b2b_latency: got %0d want 186", m_lat[base+1]);
        end
        send_frame(0, 16'h0000, 8, 16, 1, 1, 2, 2'b01, -1, 0);
        wait_vld(base + 3, 60);
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (vld_cnt !== base + 3 || m_stop[base+2] !== 1'b1
            || m_par[base+2] !== 1'b0 || m_data[base+2] !== 16'h0000) begin
            errors++;
            $display("FAIL stop2_err: got %0d/%h/%b%b want %0d/0000/01",
                     vld_cnt, m_data[base+2], m_par[base+2], m_stop[base+2],
                     base + 3);
        end
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    endtask

    task automatic test_clamp;
        int base;
        prescale = 6'd2; par_en = 1'b0; stop2 = 1'b0;
        base = vld_cnt;
        send_frame(0, 16'h003C, 8, 4, 0, 0, 1, 2'b11, -1, 0);
        wait_vld(base + 1, 30);
        checks++;
        if (vld_cnt !== base + 1 || m_data[base] !== 16'h003C
            || m_lat[base] !== 40) begin
            errors++;
            $display("FAIL clamp: got %0d/%h/%0d want %0d/003c/40",
                     vld_cnt, m_data[base], m_lat[base], base + 1);
        end
        prescale = 6'd8;
    endtask

    task automatic test_width9;
        int base;
        prescale = 6'd8; par_en = 1'b0; stop2 = 1'b0;
        base = vld2_cnt;
        send_frame(1, 16'h01A5, 9, 8, 0, 0, 1, 2'b11, -1, 0);
        for (int i = 0; i < 40 && vld2_cnt == base; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vld2_cnt !== base + 1 || d2 !== 16'h01A5) begin
            errors++;
            $display("FAIL w9_data: got %0d/%h want %0d/01a5",
                     vld2_cnt, d2, base + 1);
        end
        checks++;
        if (lat2 !== 86 || p2 !== 1'b0 || s2e !== 1'b0) begin
            errors++;
            $display("FAIL w9_timing: got %0d/%b%b want 86/00", lat2, p2, s2e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_noise();
        test_reset_mid();
        test_back_to_back();
        test_clamp();
        test_width9();
        checks++;
        if (dv_multi !== 0) begin
            errors++;
            $display("FAIL valid_width: got %0d multi-cycle pulses want 0", dv_multi);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
